// File: rtl/video_timing_gen.sv
// Raster timing generator: walks an (h, v) counter pair over the full frame and
// registers the pixel coordinates, data enable and sync/start strobes for it.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_too_small
            $error("video_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [10:0]      x_q, x_d;
    logic [10:0]      y_q, y_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             h_act, v_act;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end else begin
            h_d = h_q + CNT_W'(1);
        end

        // Decode of the pre-increment position; it lands on the outputs next edge.
        h_act = (h_q < H_ACT);
        v_act = (v_q < V_ACT);
        x_d   = h_act ? 11'(h_q) : '0;
        y_d   = v_act ? 11'(v_q) : '0;
        de_d  = h_act && v_act;
        hs_d  = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : !HS_POL;
        vs_d  = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : !VS_POL;
        ls_d  = (h_q == '0) && v_act;
        fs_d  = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
            hs_q <= !HS_POL;
            vs_q <= !VS_POL;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (en) begin
            h_q  <= h_d;
            v_q  <= v_d;
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end else begin
            // Stalled edge: position and syncs hold, per-pixel strobes are suppressed.
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a 1080p instance and a tiny-raster instance, each
// checked cycle by cycle against a pixel-index model of the raster.
module tb_video_timing_gen;

    logic clk;
    logic rst0_n, en0, rst1_n, en1;
    logic [10:0] x0, y0, x1, y1;
    logic de0, hs0, vs0, ls0, fs0;
    logic de1, hs1, vs1, ls1, fs1;

    video_timing_gen dut0 (
        .clk(clk), .rst_n(rst0_n), .en(en0),
        .x(x0), .y(y0), .de(de0), .hsync(hs0), .vsync(vs0),
        .line_start(ls0), .frame_start(fs0)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(12)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .en(en1),
        .x(x1), .y(y1), .de(de1), .hsync(hs1), .vsync(vs1),
        .line_start(ls1), .frame_start(fs1)
    );

    // Output vector layout: [26:16] x, [15:5] y, [4] de, [3] hsync, [2] vsync,
    // [1] line_start, [0] frame_start.
    logic [26:0] got0, got1;
    assign got0 = {x0, y0, de0, hs0, vs0, ls0, fs0};
    assign got1 = {x1, y1, de1, hs1, vs1, ls1, fs1};

    int  cfg_ha[2]   = '{1920, 8};
    int  cfg_hfp[2]  = '{88, 2};
    int  cfg_hsw[2]  = '{44, 2};
    int  cfg_hbp[2]  = '{148, 2};
    int  cfg_va[2]   = '{1080, 4};
    int  cfg_vfp[2]  = '{4, 1};
    int  cfg_vsw[2]  = '{5, 1};
    int  cfg_vbp[2]  = '{36, 1};
    bit  cfg_hpol[2] = '{1'b1, 1'b0};
    bit  cfg_vpol[2] = '{1'b1, 1'b1};

    logic [26:0] exp_q[$];
    longint      pix[2];
    logic [26:0] last[2];
    int          total;
    int          bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [26:0] ref_pix(input int s, input longint p);
        int ht, vt, h, v, ha, va;
        logic [10:0] xe, ye;
        logic de_e, hs_e, vs_e, ls_e, fs_e;
        ha = cfg_ha[s];
        va = cfg_va[s];
        ht = ha + cfg_hfp[s] + cfg_hsw[s] + cfg_hbp[s];
        vt = va + cfg_vfp[s] + cfg_vsw[s] + cfg_vbp[s];
        h  = int'(p % longint'(ht));
        v  = int'((p / longint'(ht)) % longint'(vt));
        xe   = (h < ha) ? 11'(h) : 11'd0;
        ye   = (v < va) ? 11'(v) : 11'd0;
        de_e = (h < ha) && (v < va);
        hs_e = (h >= ha + cfg_hfp[s] && h < ha + cfg_hfp[s] + cfg_hsw[s]) ? cfg_hpol[s] : !cfg_hpol[s];
        vs_e = (v >= va + cfg_vfp[s] && v < va + cfg_vfp[s] + cfg_vsw[s]) ? cfg_vpol[s] : !cfg_vpol[s];
        ls_e = (h == 0) && (v < va);
        fs_e = (h == 0) && (v == 0);
        return {xe, ye, de_e, hs_e, vs_e, ls_e, fs_e};
    endfunction

    function automatic logic [26:0] reset_val(input int s);
        return {11'd0, 11'd0, 1'b0, !cfg_hpol[s], !cfg_vpol[s], 2'b00};
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_vec(input int s, input string what, input logic [26:0] g, input logic [26:0] e);
        check_eq($sformatf("d%0d.%s.x", s, what),  32'(g[26:16]), 32'(e[26:16]));
        check_eq($sformatf("d%0d.%s.y", s, what),  32'(g[15:5]),  32'(e[15:5]));
        check_eq($sformatf("d%0d.%s.de", s, what), 32'(g[4]), 32'(e[4]));
        check_eq($sformatf("d%0d.%s.hs", s, what), 32'(g[3]), 32'(e[3]));
        check_eq($sformatf("d%0d.%s.vs", s, what), 32'(g[2]), 32'(e[2]));
        check_eq($sformatf("d%0d.%s.ls", s, what), 32'(g[1]), 32'(e[1]));
        check_eq($sformatf("d%0d.%s.fs", s, what), 32'(g[0]), 32'(e[0]));
    endtask

    function automatic logic [26:0] got_of(input int s);
        return (s == 0) ? got0 : got1;
    endfunction

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic step(input int s, input bit en_v);
        logic [26:0] e;
        if (s == 0) en0 = en_v; else en1 = en_v;
        if (en_v) begin
            e = ref_pix(s, pix[s]);
            pix[s]++;
        end else begin
            e = {last[s][26:5], 1'b0, last[s][3:2], 2'b00};
        end
        last[s] = e;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_vec(s, "pix", got_of(s), exp_q.pop_front());
    endtask

    // Reset asserted between edges; outputs must already be at reset values
    // before the next rising edge.
    task automatic do_reset(input int s);
        if (s == 0) en0 = 1'b0; else en1 = 1'b0;
        #2;
        if (s == 0) rst0_n = 1'b0; else rst1_n = 1'b0;
        #1;
        check_vec(s, "async_rst", got_of(s), reset_val(s));
        @(negedge clk);
        check_vec(s, "in_rst", got_of(s), reset_val(s));
        if (s == 0) rst0_n = 1'b1; else rst1_n = 1'b1;
        pix[s]  = 0;
        last[s] = reset_val(s);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ls_idx[$];
        int fs_idx[$];
        int hs_cnt, hs_first, vs_cnt;
        logic [26:0] g;

        total = 0;
        bad   = 0;
        rst0_n = 1'b0; rst1_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        repeat (2) @(negedge clk);

        // 1080p instance: first lines with en held high.
        do_reset(0);
        hs_cnt = 0;
        hs_first = -1;
        for (int k = 0; k < 3 * 2200 + 501; k++) begin
            step(0, 1'b1);
            g = got0;
            if (k == 0) begin
                check_eq("first.fs", 32'(g[0]), 1);
                check_eq("first.ls", 32'(g[1]), 1);
                check_eq("first.de", 32'(g[4]), 1);
            end
            if (k == 1919) check_eq("x_last", 32'(g[26:16]), 1919);
            if (k == 1920) begin
                check_eq("blank.de", 32'(g[4]), 0);
                check_eq("blank.x", 32'(g[26:16]), 0);
            end
            if (g[1]) ls_idx.push_back(k);
            if (k < 2200 && g[3]) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
        end
        check_eq("ls_count", 32'(ls_idx.size()), 4);
        if (ls_idx.size() >= 2) check_eq("ls_period", 32'(ls_idx[1] - ls_idx[0]), 2200);
        check_eq("hs_width", 32'(hs_cnt), 44);
        check_eq("hs_offset", 32'(hs_first), 2008);

        // Stall right after the (500, 3) pixel.
        for (int k = 0; k < 10; k++) step(0, 1'b0);
        step(0, 1'b1);
        check_eq("resume.x", 32'(got0[26:16]), 501);
        check_eq("resume.y", 32'(got0[15:5]), 3);
        check_eq("resume.de", 32'(got0[4]), 1);

        for (int k = 0; k < 1500; k++) step(0, ($urandom_range(0, 3) != 0));

        do_reset(0);
        step(0, 1'b1);
        check_eq("rst0.restart.fs", 32'(got0[0]), 1);

        // Small instance: whole frames, wrap and sync widths.
        do_reset(1);
        fs_idx.delete();
        hs_cnt = 0;
        hs_first = -1;
        vs_cnt = 0;
        for (int k = 0; k <= 2 * 98; k++) begin
            step(1, 1'b1);
            g = got1;
            if (g[0]) fs_idx.push_back(k);
            if (k < 14 && !g[3]) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (k < 98 && g[2]) vs_cnt++;
        end
        check_eq("s.fs_count", 32'(fs_idx.size()), 3);
        if (fs_idx.size() >= 2) check_eq("s.fs_period", 32'(fs_idx[1] - fs_idx[0]), 98);
        check_eq("s.hs_low_width", 32'(hs_cnt), 2);
        check_eq("s.hs_low_offset", 32'(hs_first), 10);
        check_eq("s.vs_cycles", 32'(vs_cnt), 14);

        for (int k = 0; k < 400; k++) step(1, ($urandom_range(0, 2) != 0));

        // Mid-frame reset on line 2 of the small raster.
        do_reset(1);
        for (int k = 0; k < 2 * 14 + 3; k++) step(1, 1'b1);
        check_eq("s.pre_rst.y", 32'(got1[15:5]), 2);
        do_reset(1);
        step(1, 1'b1);
        check_eq("s.restart.fs", 32'(got1[0]), 1);
        check_eq("s.restart.x", 32'(got1[26:16]), 0);
        check_eq("s.restart.y", 32'(got1[15:5]), 0);

        for (int k = 0; k < 300; k++) step(1, ($urandom_range(0, 3) != 0));

        check_eq("exp_q_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator that produces the pixel coordinates (x, y) and the sync/enable strobes for a progressive video frame. It is the upstream producer of the x/y coordinate interface consumed by the pattern generators, such as the FHD colour bar. It sits between the pixel clock domain and the pattern/TMDS path. Defaults give CEA 1080p (2200x1125 total, 1920x1080 active).

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (pixels)
H_SYNC, 44, hsync width (pixels)
H_BP, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CNT_W, 12, internal h/v counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock, rising edge
rst_n  in  1  asynchronous reset, active-low
en  in  1  pixel-advance enable (clock-enable)
x  out  11  active-area column, 0..H_ACTIVE-1
y  out  11  active-area row, 0..V_ACTIVE-1
de  out  1  data enable; high when x/y address a visible pixel
hsync  out  1  horizontal sync at HS_POL level
vsync  out  1  vertical sync at VS_POL level
line_start  out  1  1-cycle pulse with the first pixel (x=0) of each active line
frame_start  out  1  1-cycle pulse with pixel (0,0) of each frame

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt runs 0..V_TOTAL-1.
  - Both advance only on a clk edge with en=1.
  - h_cnt wraps to 0 after H_TOTAL-1. v_cnt increments on that h wrap and wraps to 0 after V_TOTAL-1.
- Decode of the current (h_cnt, v_cnt):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs is line-aligned and changes at h_cnt=0.
- Output register: all outputs are registered and mutually aligned. On each en=1 edge:
  - Outputs load the decode of the pre-increment counters.
  - de=active.
  - x = h_cnt[10:0] when h_cnt<H_ACTIVE, else 0.
  - y = v_cnt[10:0] when v_cnt<V_ACTIVE, else 0.
  - hsync = hs ? HS_POL : !HS_POL; vsync = vs ? VS_POL : !VS_POL.
  - line_start = (h_cnt==0 && v_cnt<V_ACTIVE).
  - frame_start = (h_cnt==0 && v_cnt==0).
- Latency: exactly 1 en-cycle from counter state to outputs. x/y never exceed H_ACTIVE-1/V_ACTIVE-1, so 11-bit consumers never see blanking counts above 2047.
- en=0: counters hold. x, y, hsync and vsync hold. de, line_start and frame_start are forced to 0 on that edge. No pixel is skipped or repeated when en returns.
- Reset (rst_n low, asynchronous, immediate):
  - Counters, x, y, de, line_start and frame_start go to 0.
  - hsync = !HS_POL; vsync = !VS_POL.
  - First en=1 edge after release: x=0, y=0, de=1, line_start=1, frame_start=1.
- Reset mid-frame: outputs drop to reset values without waiting for a clock edge. Counting restarts at (0,0); no partial-frame state survives.
- Pulses: line_start and frame_start are exactly 1 clk wide, and only when the preceding edge had en=1.
- Arithmetic: comparisons use CNT_W-bit unsigned arithmetic with no overflow. An elaboration-time check fails if H_TOTAL > 2^CNT_W or V_TOTAL > 2^CNT_W.

Test Plan:
1. Release reset, en=1 constant, defaults:
   - First edge: x=0, y=0, de=1, frame_start=1, line_start=1.
   - x counts 0..1919 over 1920 cycles; the next cycle has de=0 and x=0.
2. Line timing, defaults:
   - hsync high for exactly 44 cycles, starting 2008 cycles after line_start.
   - line_start period is 2200 cycles.
   - No line_start on lines 1080..1124.
3. Frame timing, defaults:
   - vsync high for exactly 5 lines (5×2200 cycles), starting 1084×2200 cycles after frame_start.
   - frame_start period is 2,475,000 cycles.
   - de-high count per frame is 2,073,600.
4. Wrap: run to the pixel (h=2199, v=1124); the next output cycle is x=0, y=0, de=1, frame_start=1.
5. Stall: drop en for 10 cycles right after the x=500, y=3 output.
   - x/y/hsync/vsync hold; de=0 throughout.
   - On resume, the first output is x=501, y=3, de=1.
6. Async reset mid-frame at y=600, between clock edges:
   - Outputs go to reset values before the next edge.
   - After release, the sequence restarts at (0,0) with frame_start=1.
   - Repeat with small parameters (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=0): hsync low for 2 cycles at h_cnt 10..11, frame period 98 cycles.
